pd_seq_ctrl: RTL and testbench

Parametrised power-domain sequencer for the PMU that moves each of `NUM_PD` domains independently between OFF, ON and RETENTION. Each domain has a request/acknowledge handshake. Domain outputs (rail enable, switch enable, isolation, retention, clock enable) are driven in a fixed safe order with programmable settling times. Per-domain power-good is monitored with a timeout. A single shared sequencer serves requests one at a time under round-robin arbitration.

---
 rtl/pd_seq_ctrl_if.sv | 32 +++
 rtl/pd_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_pd_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pd_seq_ctrl_if.sv
// Request/acknowledge and per-domain control bundle between the PMU sequencer
// and its power domains.
interface pd_seq_ctrl_if #(
  parameter int NUM_PD = 10
);
  logic [NUM_PD-1:0]   pd_req;
  logic [2*NUM_PD-1:0] pd_mode;
  logic [NUM_PD-1:0]   pd_ack;
  logic [2*NUM_PD-1:0] pd_state;
  logic [NUM_PD-1:0]   vreg_en;
  logic [NUM_PD-1:0]   vreg_pg;
  logic [NUM_PD-1:0]   pd_enable;
  logic [NUM_PD-1:0]   pd_iso_n;
  logic [NUM_PD-1:0]   pd_ret_n;
  logic [NUM_PD-1:0]   pd_clk_en;
  logic                busy;
  logic                err_valid;
  logic [4:0]          err_pd;
  logic [1:0]          err_code;

  modport master (
    output pd_req, pd_mode, vreg_pg,
    input  pd_ack, pd_state, vreg_en, pd_enable, pd_iso_n, pd_ret_n,
           pd_clk_en, busy, err_valid, err_pd, err_code
  );

  modport slave (
    input  pd_req, pd_mode, vreg_pg,
    output pd_ack, pd_state, vreg_en, pd_enable, pd_iso_n, pd_ret_n,
           pd_clk_en, busy, err_valid, err_pd, err_code
  );
endinterface

// File: rtl/pd_seq_ctrl.sv
// Shared power-domain sequencer: one round-robin-granted domain at a time is
// walked between OFF, ON and RETENTION with timed, safely ordered steps.
module pd_seq_ctrl #(
  parameter int NUM_PD   = 10,
  parameter int TIMER_W  = 16,
  parameter int T_ISO    = 5,
  parameter int T_CLK    = 10,
  parameter int T_RET    = 20,
  parameter int T_PG_TMO = 100
) (
  input  logic         clk,
  input  logic         rstn,
  pd_seq_ctrl_if.slave pd
);

  localparam int IDX_W = (NUM_PD > 1) ? $clog2(NUM_PD) : 1;

  localparam logic [1:0] ST_OFF = 2'b00;
  localparam logic [1:0] ST_ON  = 2'b01;
  localparam logic [1:0] ST_RET = 2'b10;
  localparam logic [1:0] ST_ILL = 2'b11;

  localparam logic [1:0] ERR_TMO = 2'b01;
  localparam logic [1:0] ERR_ILL = 2'b10;

  // Timed steps finish when the timer shows T-1 (timer is 0 in the first cycle).
  localparam logic [TIMER_W-1:0] ISO_LAST = TIMER_W'(T_ISO - 1);
  localparam logic [TIMER_W-1:0] CLK_LAST = TIMER_W'(T_CLK - 1);
  localparam logic [TIMER_W-1:0] RET_LAST = TIMER_W'(T_RET - 1);
  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(T_PG_TMO - 1);

  typedef enum logic [2:0] {
    IDLE,
    PG_WAIT,
    ISO_WAIT,
    RET_WAIT,
    CLK_WAIT,
    DONE
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [1:0]          cur_q;
  logic [1:0]          tgt_q;
  logic [TIMER_W-1:0]  tmr_q;

  logic [NUM_PD-1:0]   vreg_q;
  logic [NUM_PD-1:0]   en_q;
  logic [NUM_PD-1:0]   iso_n_q;
  logic [NUM_PD-1:0]   ret_n_q;
  logic [NUM_PD-1:0]   clk_en_q;
  logic [NUM_PD-1:0]   ack_q;
  logic [2*NUM_PD-1:0] st_q;
  logic                busy_q;
  logic                errv_q;
  logic [4:0]          errpd_q;
  logic [1:0]          errcode_q;

  logic                gnt_vld_d;
  logic [IDX_W-1:0]    gnt_idx_d;
  logic [1:0]          gnt_mode_d;
  logic [1:0]          gnt_cur_d;

  function automatic logic is_illegal(input logic [1:0] cur, input logic [1:0] tgt);
    return (tgt == ST_ILL) || ((cur == ST_OFF) && (tgt == ST_RET));
  endfunction

  // Round-robin search from the pointer; the lowest offset with a request wins.
  always_comb begin
    int j;
    gnt_vld_d = 1'b0;
    gnt_idx_d = '0;
    j         = 0;
    for (int k = NUM_PD - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_PD) j = j - NUM_PD;
      if (pd.pd_req[j]) begin
        gnt_vld_d = 1'b1;
        gnt_idx_d = IDX_W'(j);
      end
    end
  end

  assign gnt_mode_d = pd.pd_mode[{gnt_idx_d, 1'b0} +: 2];
  assign gnt_cur_d  = st_q[{gnt_idx_d, 1'b0} +: 2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      cur_q     <= ST_OFF;
      tgt_q     <= ST_OFF;
      tmr_q     <= '0;
      vreg_q    <= '0;
      en_q      <= '0;
      iso_n_q   <= '0;
      ret_n_q   <= '1;
      clk_en_q  <= '0;
      ack_q     <= '0;
      st_q      <= '0;
      busy_q    <= 1'b0;
      errv_q    <= 1'b0;
      errpd_q   <= '0;
      errcode_q <= '0;
    end else begin
      ack_q  <= '0;
      errv_q <= 1'b0;
      tmr_q  <= tmr_q + TIMER_W'(1);

      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            idx_q  <= gnt_idx_d;
            cur_q  <= gnt_cur_d;
            tgt_q  <= gnt_mode_d;
            tmr_q  <= '0;
            busy_q <= 1'b1;
            if (is_illegal(gnt_cur_d, gnt_mode_d)) begin
              ack_q[gnt_idx_d] <= 1'b1;
              errv_q           <= 1'b1;
              errpd_q          <= 5'(gnt_idx_d);
              errcode_q        <= ERR_ILL;
              state_q          <= DONE;
            end else if (gnt_cur_d == gnt_mode_d) begin
              ack_q[gnt_idx_d] <= 1'b1;
              state_q          <= DONE;
            end else begin
              case ({gnt_cur_d, gnt_mode_d})
                {ST_OFF, ST_ON}: begin
                  vreg_q[gnt_idx_d] <= 1'b1;
                  en_q[gnt_idx_d]   <= 1'b1;
                  state_q           <= PG_WAIT;
                end
                {ST_RET, ST_ON}: begin
                  en_q[gnt_idx_d] <= 1'b1;
                  state_q         <= PG_WAIT;
                end
                {ST_RET, ST_OFF}: begin
                  // Isolation is already asserted in retention and stays so.
                  ret_n_q[gnt_idx_d]             <= 1'b1;
                  vreg_q[gnt_idx_d]              <= 1'b0;
                  st_q[{gnt_idx_d, 1'b0} +: 2]   <= ST_OFF;
                  ack_q[gnt_idx_d]               <= 1'b1;
                  state_q                        <= DONE;
                end
                default: begin
                  // ON -> OFF and ON -> RET both start by stopping the clock.
                  clk_en_q[gnt_idx_d] <= 1'b0;
                  state_q             <= CLK_WAIT;
                end
              endcase
            end
          end
        end

        PG_WAIT: begin
          if (pd.vreg_pg[idx_q]) begin
            tmr_q <= '0;
            if (cur_q == ST_OFF) begin
              state_q <= ISO_WAIT;
            end else begin
              ret_n_q[idx_q] <= 1'b1;
              state_q        <= RET_WAIT;
            end
          end else if (tmr_q == TMO_LAST) begin
            tmr_q                      <= '0;
            en_q[idx_q]                <= 1'b0;
            vreg_q[idx_q]              <= 1'b0;
            iso_n_q[idx_q]             <= 1'b0;
            ret_n_q[idx_q]             <= 1'b1;
            st_q[{idx_q, 1'b0} +: 2]   <= ST_OFF;
            ack_q[idx_q]               <= 1'b1;
            errv_q                     <= 1'b1;
            errpd_q                    <= 5'(idx_q);
            errcode_q                  <= ERR_TMO;
            state_q                    <= DONE;
          end
        end

        ISO_WAIT: begin
          if (tmr_q == ISO_LAST) begin
            tmr_q <= '0;
            case (tgt_q)
              ST_ON: begin
                iso_n_q[idx_q] <= 1'b1;
                state_q        <= CLK_WAIT;
              end
              ST_RET: begin
                ret_n_q[idx_q] <= 1'b0;
                state_q        <= RET_WAIT;
              end
              default: begin
                en_q[idx_q]              <= 1'b0;
                vreg_q[idx_q]            <= 1'b0;
                st_q[{idx_q, 1'b0} +: 2] <= ST_OFF;
                ack_q[idx_q]             <= 1'b1;
                state_q                  <= DONE;
              end
            endcase
          end
        end

        RET_WAIT: begin
          if (tmr_q == RET_LAST) begin
            tmr_q <= '0;
            if (tgt_q == ST_ON) begin
              iso_n_q[idx_q] <= 1'b1;
              state_q        <= CLK_WAIT;
            end else begin
              // Retention keeps the rail up; only the main switch opens.
              en_q[idx_q]              <= 1'b0;
              st_q[{idx_q, 1'b0} +: 2] <= ST_RET;
              ack_q[idx_q]             <= 1'b1;
              state_q                  <= DONE;
            end
          end
        end

        CLK_WAIT: begin
          if (tmr_q == CLK_LAST) begin
            tmr_q <= '0;
            if (tgt_q == ST_ON) begin
              clk_en_q[idx_q]          <= 1'b1;
              st_q[{idx_q, 1'b0} +: 2] <= ST_ON;
              ack_q[idx_q]             <= 1'b1;
              state_q                  <= DONE;
            end else begin
              iso_n_q[idx_q] <= 1'b0;
              state_q        <= ISO_WAIT;
            end
          end
        end

        DONE: begin
          tmr_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (int'(idx_q) == NUM_PD - 1) ? '0 : idx_q + IDX_W'(1);
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pd.pd_ack    = ack_q;
  assign pd.pd_state  = st_q;
  assign pd.vreg_en   = vreg_q;
  assign pd.pd_enable = en_q;
  assign pd.pd_iso_n  = iso_n_q;
  assign pd.pd_ret_n  = ret_n_q;
  assign pd.pd_clk_en = clk_en_q;
  assign pd.busy      = busy_q;
  assign pd.err_valid = errv_q;
  assign pd.err_pd    = errpd_q;
  assign pd.err_code  = errcode_q;

endmodule

// File: tb/tb_pd_seq_ctrl.sv
// Randomized bench for pd_seq_ctrl; expected outputs come from a timeline of
// output events derived from the sequencing rules.
module tb_pd_seq_ctrl;
  localparam int NUM_PD   = 10;
  localparam int TIMER_W  = 16;
  localparam int T_ISO    = 5;
  localparam int T_CLK    = 10;
  localparam int T_RET    = 20;
  localparam int T_PG_TMO = 100;
  localparam int NEVER    = 100000;

  localparam logic [1:0] ST_OFF = 2'b00;
  localparam logic [1:0] ST_ON  = 2'b01;
  localparam logic [1:0] ST_RET = 2'b10;
  localparam logic [1:0] ST_ILL = 2'b11;

  localparam int F_VREG = 0;
  localparam int F_EN   = 1;
  localparam int F_ISO  = 2;
  localparam int F_RET  = 3;
  localparam int F_CLK  = 4;

  typedef struct {
    int at_edge;
    int fld;
    bit val;
  } ev_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pd_seq_ctrl_if #(.NUM_PD(NUM_PD)) pd_bus ();

  pd_seq_ctrl #(
    .NUM_PD  (NUM_PD),
    .TIMER_W (TIMER_W),
    .T_ISO   (T_ISO),
    .T_CLK   (T_CLK),
    .T_RET   (T_RET),
    .T_PG_TMO(T_PG_TMO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .pd  (pd_bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [NUM_PD-1:0]   m_vreg, m_en, m_iso, m_ret, m_clk;
  logic [2*NUM_PD-1:0] m_st;
  int                  m_ptr;
  ev_t                 evq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vreg = '0; m_en = '0; m_iso = '0; m_ret = '1; m_clk = '0;
    m_st   = '0; m_ptr = 0;
    evq.delete();
  endtask

  task automatic check_outs(input logic [NUM_PD-1:0] exp_ack, input bit exp_busy, input bit exp_errv);
    check("vreg_en",   64'(pd_bus.vreg_en),   64'(m_vreg));
    check("pd_enable", 64'(pd_bus.pd_enable), 64'(m_en));
    check("pd_iso_n",  64'(pd_bus.pd_iso_n),  64'(m_iso));
    check("pd_ret_n",  64'(pd_bus.pd_ret_n),  64'(m_ret));
    check("pd_clk_en", 64'(pd_bus.pd_clk_en), 64'(m_clk));
    check("pd_state",  64'(pd_bus.pd_state),  64'(m_st));
    check("pd_ack",    64'(pd_bus.pd_ack),    64'(exp_ack));
    check("busy",      64'(pd_bus.busy),      64'(exp_busy));
    check("err_valid", 64'(pd_bus.err_valid), 64'(exp_errv));
  endtask

  task automatic add_ev(input int e, input int f, input bit v);
    evq.push_back('{at_edge: e, fld: f, val: v});
  endtask

  // Edge 0 is the grant edge; p is the first edge on which power-good is sampled high.
  task automatic plan(input int i, input logic [1:0] tgt, input int p,
                      output int a, output logic [1:0] fin, output logic [1:0] errc);
    logic [1:0] cur;
    cur  = m_st[2*i +: 2];
    fin  = cur;
    errc = 2'b00;
    a    = 0;
    evq.delete();
    if (tgt == ST_ILL || (cur == ST_OFF && tgt == ST_RET)) begin
      errc = 2'b10;
    end else if (tgt == cur) begin
      a = 0;
    end else if (tgt == ST_ON) begin
      if (cur == ST_OFF) begin
        add_ev(0, F_VREG, 1'b1);
        add_ev(0, F_EN, 1'b1);
      end else begin
        add_ev(0, F_EN, 1'b1);
      end
      if (p <= T_PG_TMO) begin
        if (cur == ST_OFF) begin
          add_ev(p + T_ISO, F_ISO, 1'b1);
          a = p + T_ISO + T_CLK;
        end else begin
          add_ev(p, F_RET, 1'b1);
          add_ev(p + T_RET, F_ISO, 1'b1);
          a = p + T_RET + T_CLK;
        end
        add_ev(a, F_CLK, 1'b1);
        fin = ST_ON;
      end else begin
        a = T_PG_TMO;
        add_ev(a, F_EN, 1'b0);
        add_ev(a, F_VREG, 1'b0);
        add_ev(a, F_ISO, 1'b0);
        add_ev(a, F_RET, 1'b1);
        fin  = ST_OFF;
        errc = 2'b01;
      end
    end else if (cur == ST_ON) begin
      add_ev(0, F_CLK, 1'b0);
      add_ev(T_CLK, F_ISO, 1'b0);
      if (tgt == ST_OFF) begin
        a = T_CLK + T_ISO;
        add_ev(a, F_EN, 1'b0);
        add_ev(a, F_VREG, 1'b0);
      end else begin
        add_ev(T_CLK + T_ISO, F_RET, 1'b0);
        a = T_CLK + T_ISO + T_RET;
        add_ev(a, F_EN, 1'b0);
      end
      fin = tgt;
    end else begin
      add_ev(0, F_RET, 1'b1);
      add_ev(0, F_VREG, 1'b0);
      fin = ST_OFF;
    end
  endtask

  task automatic apply_ev(input int i, input int e);
    foreach (evq[n]) begin
      if (evq[n].at_edge == e) begin
        case (evq[n].fld)
          F_VREG:  m_vreg[i] = evq[n].val;
          F_EN:    m_en[i]   = evq[n].val;
          F_ISO:   m_iso[i]  = evq[n].val;
          F_RET:   m_ret[i]  = evq[n].val;
          default: m_clk[i]  = evq[n].val;
        endcase
      end
    end
  endtask

  // Called with the sequencer idle; returns at the falling edge of the idle
  // cycle that follows DONE.
  task automatic run_txn(input int i, input logic [1:0] tgt, input int p);
    int a;
    logic [1:0] fin, errc;
    logic [NUM_PD-1:0] exp_ack;
    plan(i, tgt, p, a, fin, errc);
    pd_bus.pd_mode[2*i +: 2] = tgt;
    pd_bus.pd_req[i]         = 1'b1;
    pd_bus.vreg_pg[i]        = (p <= 1);
    for (int k = 1; k <= a + 2; k++) begin
      @(posedge clk);
      apply_ev(i, k - 1);
      if (k - 1 == a) begin
        m_st[2*i +: 2] = fin;
        m_ptr = (i + 1) % NUM_PD;
      end
      #1;
      if (k - 1 == a + 1) pd_bus.pd_req[i] = 1'b0;
      if (k == p) pd_bus.vreg_pg[i] = 1'b1;
      @(negedge clk);
      exp_ack = '0;
      if (k == a + 1) exp_ack[i] = 1'b1;
      check_outs(exp_ack, (k <= a + 1), (k == a + 1) && (errc != 2'b00));
      if (k == a + 1 && errc != 2'b00) begin
        check("err_pd",   64'(pd_bus.err_pd),   64'(i));
        check("err_code", 64'(pd_bus.err_code), 64'(errc));
      end
    end
  endtask

  function automatic int rr_pick(input logic [NUM_PD-1:0] pend, input int ptr);
    for (int k = 0; k < NUM_PD; k++) begin
      if (pend[(ptr + k) % NUM_PD]) return (ptr + k) % NUM_PD;
    end
    return 0;
  endfunction

  task automatic serve_pending(input logic [NUM_PD-1:0] pend_in, input logic [1:0] tgt);
    logic [NUM_PD-1:0] pend;
    int d;
    pend = pend_in;
    for (int n = 0; n < NUM_PD; n++) begin
      if (pend[n]) begin
        pd_bus.pd_mode[2*n +: 2] = tgt;
        pd_bus.pd_req[n]         = 1'b1;
      end
    end
    while (pend != '0) begin
      d = rr_pick(pend, m_ptr);
      run_txn(d, tgt, $urandom_range(1, 4));
      pend[d] = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, r, p;
    logic [1:0] tgt;
    pd_bus.pd_req  = '0;
    pd_bus.pd_mode = '0;
    pd_bus.vreg_pg = '0;
    model_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs('0, 1'b0, 1'b0);
    check("rst_err_pd",   64'(pd_bus.err_pd),   64'(0));
    check("rst_err_code", 64'(pd_bus.err_code), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Directed scenarios
    run_txn(3, ST_ON, 1);
    run_txn(3, ST_RET, 1);
    run_txn(3, ST_ON, 3);
    run_txn(7, ST_ON, NEVER);
    run_txn(7, ST_ON, T_PG_TMO);
    run_txn(7, ST_OFF, 1);
    run_txn(5, ST_ILL, 1);
    run_txn(5, ST_RET, 1);
    run_txn(4, ST_OFF, 1);
    serve_pending(10'b10_0001_0001, ST_ON);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      i = $urandom_range(0, NUM_PD - 1);
      r = $urandom_range(0, 9);
      tgt = (r == 0) ? ST_ILL : 2'(r % 3);
      r = $urandom_range(0, 7);
      p = (r == 0) ? 1 : (r == 1) ? T_PG_TMO : (r == 2) ? T_PG_TMO + 1 : $urandom_range(1, 20);
      run_txn(i, tgt, p);
    end

    // Reset while a power-up is in its clock-settling step
    run_txn(3, ST_OFF, 1);
    pd_bus.pd_mode[2*3 +: 2] = ST_ON;
    pd_bus.pd_req[3]         = 1'b1;
    pd_bus.vreg_pg[3]        = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    pd_bus.pd_req = '0;
    model_reset();
    check_outs('0, 1'b0, 1'b0);
    check("rst_mid_err_pd",   64'(pd_bus.err_pd),   64'(0));
    check("rst_mid_err_code", 64'(pd_bus.err_code), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    serve_pending(10'b01_0000_0100, ST_ON);
    run_txn(2, ST_RET, 1);
    run_txn(2, ST_OFF, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
